systolic_ctrl: RTL and testbench

SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

---
 rtl/systolic_pkg.sv | 23 ++
 rtl/systolic_ctrl_skew.sv | 39 +++
 rtl/systolic_ctrl.sv | 155 +++++++++++++++
 tb/tb_systolic_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and cycle-count helpers for the systolic array controller.
// Holds the controller state enum and FEED/DRAIN phase lengths.
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    DONE
  } state_t;

  function automatic int feed_cycles(input int n);
    return n;
  endfunction

  // One read-latency cycle plus 2N-2 cycles for the wavefront to
  // reach the far corner PE.
  function automatic int drain_cycles(input int n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/systolic_ctrl_skew.sv
// skew_buffer: triangular delay lines; lane i is delayed i cycles.
// Ports: clk_i, rst_i, vld_i (input qualifier), data_i, data_o (skewed).
module skew_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int N          = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  vld_i,
  input  logic [N*DATA_WIDTH-1:0] data_i,
  output logic [N*DATA_WIDTH-1:0] data_o
);

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] in_d;

    // Unqualified cycles inject zeros so idle PEs accumulate nothing.
    assign in_d = vld_i ? data_i[i*DATA_WIDTH +: DATA_WIDTH]
                        : '0;

    if (i == 0) begin : g_pass
      assign data_o[DATA_WIDTH-1:0] = in_d;
    end else begin : g_dly
      logic [DATA_WIDTH-1:0] sr_q [i];

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          for (int s = 0; s < i; s++) sr_q[s] <= '0;
        end else begin
          sr_q[0] <= in_d;
          for (int s = 1; s < i; s++) sr_q[s] <= sr_q[s-1];
        end
      end

      assign data_o[i*DATA_WIDTH +: DATA_WIDTH] = sr_q[i-1];
    end
  end

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for an N x N output-stationary systolic array: clears PEs,
// reads N operand columns/rows, skews them into the array, drains, and
// pulses done_o.
// Ports: clk_i, rst_i, start_i, busy_o, done_o, rd_en_o, k_addr_o,
// a_data_i, b_data_i, left_o, up_o, pe_clr_o, and perf_cnt_o when
// SYSTOLIC_PERF_CNT_EN is defined (saturating busy-cycle count).
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int N          = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    rd_en_o,
  output logic [$clog2(N)-1:0]    k_addr_o,
  input  logic [N*DATA_WIDTH-1:0] a_data_i,
  input  logic [N*DATA_WIDTH-1:0] b_data_i,
  output logic [N*DATA_WIDTH-1:0] left_o,
  output logic [N*DATA_WIDTH-1:0] up_o,
`ifdef SYSTOLIC_PERF_CNT_EN
  output logic [31:0]             perf_cnt_o,
`endif
  output logic                    pe_clr_o
);

  localparam int KW = $clog2(N);
  localparam int CW = $clog2(2 * N);

  localparam logic [CW-1:0] FEED_LAST  = CW'(feed_cycles(N) - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(drain_cycles(N) - 1);

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            busy_q;
  logic            done_q;
  logic            rd_q;
  logic            clr_q;
  logic [KW-1:0]   k_q;
  logic            vld_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= 1'b0;
      clr_q   <= 1'b0;
      k_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            clr_q   <= 1'b1;
          end
        end
        CLEAR: begin
          state_q <= FEED;
          cnt_q   <= '0;
          clr_q   <= 1'b0;
          rd_q    <= 1'b1;
          k_q     <= '0;
        end
        FEED: begin
          if (cnt_q == FEED_LAST) begin
            state_q <= DRAIN;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            k_q     <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            k_q   <= KW'(cnt_q + 1'b1);
          end
        end
        DRAIN: begin
          if (cnt_q == DRAIN_LAST) begin
            state_q <= DONE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          rd_q    <= 1'b0;
          clr_q   <= 1'b0;
          k_q     <= '0;
        end
      endcase
    end
  end

  // Operand memory returns data one cycle after the read strobe.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) vld_q <= 1'b0;
    else       vld_q <= rd_q;
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign rd_en_o  = rd_q;
  assign pe_clr_o = clr_q;
  assign k_addr_o = k_q;

  skew_buffer #(
    .DATA_WIDTH(DATA_WIDTH),
    .N         (N)
  ) u_skew_a (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .vld_i (vld_q),
    .data_i(a_data_i),
    .data_o(left_o)
  );

  skew_buffer #(
    .DATA_WIDTH(DATA_WIDTH),
    .N         (N)
  ) u_skew_b (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .vld_i (vld_q),
    .data_i(b_data_i),
    .data_o(up_o)
  );

`ifdef SYSTOLIC_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                    perf_q <= '0;
    else if (busy_q && ~&perf_q)  perf_q <= perf_q + 1'b1;
  end

  assign perf_cnt_o = perf_q;
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl with an N=4 output-stationary PE model.
// Build with or without SYSTOLIC_PERF_CNT_EN.
module tb_systolic_ctrl;

  localparam int N  = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_i;
  logic            start_i;
  logic            busy_o;
  logic            done_o;
  logic            rd_en_o;
  logic [1:0]      k_addr_o;
  logic [N*DW-1:0] a_data_i;
  logic [N*DW-1:0] b_data_i;
  logic [N*DW-1:0] left_o;
  logic [N*DW-1:0] up_o;
  logic            pe_clr_o;
`ifdef SYSTOLIC_PERF_CNT_EN
  logic [31:0]     perf_cnt_o;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  logic [N*DW-1:0] mem_a [N];
  logic [N*DW-1:0] mem_b [N];
  logic [DW-1:0]   pe_acc [N][N];
  logic [DW-1:0]   pe_a   [N][N];
  logic [DW-1:0]   pe_b   [N][N];

  int b_tab [N][N] = '{'{1, 2, 3, 4},
                       '{5, 6, 7, 8},
                       '{9, 10, 11, 12},
                       '{13, 14, 15, 16}};

  always #5 clk = ~clk;

  systolic_ctrl #(
    .DATA_WIDTH(DW),
    .N         (N)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .rd_en_o   (rd_en_o),
    .k_addr_o  (k_addr_o),
    .a_data_i  (a_data_i),
    .b_data_i  (b_data_i),
    .left_o    (left_o),
    .up_o      (up_o),
`ifdef SYSTOLIC_PERF_CNT_EN
    .perf_cnt_o(perf_cnt_o),
`endif
    .pe_clr_o  (pe_clr_o)
  );

  // Output-stationary PE grid: A flows right, B flows down.
  always @(posedge clk or posedge rst_i) begin
    logic [DW-1:0] ai;
    logic [DW-1:0] bi;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (rst_i || pe_clr_o) begin
          pe_acc[i][j] <= '0;
          pe_a[i][j]   <= '0;
          pe_b[i][j]   <= '0;
        end else begin
          ai = (j == 0) ? left_o[i*DW +: DW] : pe_a[i][j-1];
          bi = (i == 0) ? up_o[j*DW +: DW]   : pe_b[i-1][j];
          pe_acc[i][j] <= pe_acc[i][j] + ai * bi;
          pe_a[i][j]   <= ai;
          pe_b[i][j]   <= bi;
        end
      end
    end
  end

  // Advance one cycle; the memory answers the previous cycle's read.
  task automatic step();
    logic       r;
    logic [1:0] k;
    r = rd_en_o;
    k = k_addr_o;
    @(posedge clk);
    #1;
    a_data_i = r ? mem_a[k] : {N{32'hBADC_0DE5}};
    b_data_i = r ? mem_b[k] : {N{32'h5EED_F00D}};
    #1;
  endtask

  task automatic clear_mem();
    for (int k = 0; k < N; k++) begin
      mem_a[k] = '0;
      mem_b[k] = '0;
    end
  endtask

  task automatic run_seq(input string nm, input bit chk_pe);
    logic [5:0] got;
    logic [5:0] exp;
    logic       e_rd;
    start_i = 1'b1;
    for (int c = 0; c < 15; c++) begin
      if (c > 0) begin
        step();
        start_i = 1'b0;
      end
      e_rd = (c >= 2 && c <= 5);
      exp  = {(c >= 1 && c <= 12), (c == 13), e_rd,
              (c == 1), (e_rd ? 2'(c - 2) : 2'd0)};
      got  = {busy_o, done_o, rd_en_o, pe_clr_o, k_addr_o};
      n_chk++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s cyc%0d ctl got %b want %b", nm, c, got, exp);
      end
      if (c == 0 || c == 1 || c == 14) begin
        n_chk++;
        if ({left_o, up_o} !== '0) begin
          n_fail++;
          $display("FAIL %s cyc%0d skew_zero got %h %h want 0",
                   nm, c, left_o, up_o);
        end
      end
      if (chk_pe && c == 13) begin
        for (int i = 0; i < N; i++) begin
          for (int j = 0; j < N; j++) begin
            n_chk++;
            if (pe_acc[i][j] !== DW'(b_tab[i][j])) begin
              n_fail++;
              $display("FAIL %s pe%0d%0d got %0d want %0d",
                       nm, i, j, pe_acc[i][j], b_tab[i][j]);
            end
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_i    = 1'b1;
    start_i  = 1'b0;
    a_data_i = {N{32'hBADC_0DE5}};
    b_data_i = {N{32'h5EED_F00D}};
    clear_mem();
    #1;
    n_chk++;
    if ({busy_o, done_o, rd_en_o, pe_clr_o, k_addr_o, left_o, up_o} !== '0) begin
      n_fail++;
      $display("FAIL reset outs got %b%b%b%b %h %h %h want 0",
               busy_o, done_o, rd_en_o, pe_clr_o, k_addr_o, left_o, up_o);
    end
    step();
    step();
    rst_i = 1'b0;
    step();
  endtask

  task automatic test_sequence();
    clear_mem();
    run_seq("seq", 1'b0);
  endtask

  task automatic test_identity();
    clear_mem();
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        mem_a[k][i*DW +: DW] = (i == k) ? 32'd1 : 32'd0;
        mem_b[k][i*DW +: DW] = DW'(b_tab[k][i]);
      end
    end
    run_seq("ident", 1'b1);
  endtask

  task automatic test_skew();
    logic [DW-1:0] exp;
    clear_mem();
    mem_a[0][3*DW +: DW] = 32'hA5;
    start_i = 1'b1;
    for (int c = 0; c < 15; c++) begin
      if (c > 0) begin
        step();
        start_i = 1'b0;
      end
      exp = (c == 6) ? 32'hA5 : 32'h0;
      n_chk++;
      if (left_o[3*DW +: DW] !== exp) begin
        n_fail++;
        $display("FAIL skew cyc%0d lane3 got %h want %h",
                 c, left_o[3*DW +: DW], exp);
      end
    end
  endtask

  task automatic test_hold();
    logic [2:0] got;
    logic [2:0] exp;
    clear_mem();
    start_i = 1'b1;
    for (int c = 0; c < 29; c++) begin
      if (c > 0) step();
      if (c == 19) start_i = 1'b0;
      exp = {((c >= 1 && c <= 12) || (c >= 15 && c <= 26)),
             (c == 13 || c == 27), (c == 1 || c == 15)};
      got = {busy_o, done_o, pe_clr_o};
      n_chk++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL hold cyc%0d bsy_dn_clr got %b want %b", c, got, exp);
      end
    end
    start_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    clear_mem();
    start_i = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      step();
      start_i = 1'b0;
    end
    rst_i = 1'b1;
    #1;
    n_chk++;
    if ({busy_o, done_o, rd_en_o, pe_clr_o, k_addr_o, left_o, up_o} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid outs got %b%b%b%b %h %h %h want 0",
               busy_o, done_o, rd_en_o, pe_clr_o, k_addr_o, left_o, up_o);
    end
    step();
    step();
    rst_i = 1'b0;
    for (int c = 9; c < 18; c++) begin
      n_chk++;
      if ({busy_o, done_o} !== 2'b00) begin
        n_fail++;
        $display("FAIL rst_mid cyc%0d bsy_dn got %b want 00",
                 c, {busy_o, done_o});
      end
      step();
    end
    run_seq("after_rst", 1'b0);
  endtask

`ifdef SYSTOLIC_PERF_CNT_EN
  task automatic test_perf();
    rst_i = 1'b1;
    #1;
    rst_i = 1'b0;
    #1;
    n_chk++;
    if (perf_cnt_o !== 32'd0) begin
      n_fail++;
      $display("FAIL perf_rst got %0d want 0", perf_cnt_o);
    end
    run_seq("perf1", 1'b0);
    run_seq("perf2", 1'b0);
    n_chk++;
    if (perf_cnt_o !== 32'd24) begin
      n_fail++;
      $display("FAIL perf_cnt got %0d want 24", perf_cnt_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sequence();
    test_identity();
    test_skew();
    test_hold();
    test_reset_mid();
`ifdef SYSTOLIC_PERF_CNT_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
